// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings
// driven by the E-stage control decode, plus the default operation latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MFHI  = 3'd4,
    MDU_MFLO  = 3'd5,
    MDU_MTHI  = 3'd6,
    MDU_MTLO  = 3'd7
  } mduOp_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// busy latency, and serves mfhi/mflo/mthi/mtlo.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        we,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] counter;
  mduOp_e        opReg;
  logic [31:0]   aReg, bReg;
  logic [63:0]   prodS, prodU;
  logic [31:0]   quotS, remS, quotU, remU;
  logic          accept, write, bNonZero;

  assign busy     = (counter != '0);
  assign accept   = start && !req && !busy;
  assign write    = we && !start && !req && !busy;
  assign bNonZero = (bReg != '0);

  // Operands are sign/zero-extended explicitly so the low 64 bits are exact.
  assign prodS = $signed({{32{aReg[31]}}, aReg}) * $signed({{32{bReg[31]}}, bReg});
  assign prodU = {32'b0, aReg} * {32'b0, bReg};

  // The most-negative / -1 case overflows the quotient, so it is pinned to
  // the architectural result instead of relying on the operator.
  always_comb begin
    quotS = '0;
    remS  = '0;
    quotU = '0;
    remU  = '0;
    if (bNonZero) begin
      quotU = aReg / bReg;
      remU  = aReg % bReg;
      if (aReg == 32'h8000_0000 && bReg == 32'hFFFF_FFFF) begin
        quotS = 32'h8000_0000;
        remS  = '0;
      end else begin
        quotS = $signed(aReg) / $signed(bReg);
        remS  = $signed(aReg) % $signed(bReg);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      aReg    <= '0;
      bReg    <= '0;
      opReg   <= MDU_MULT;
    end else if (accept) begin
      aReg    <= A;
      bReg    <= B;
      opReg   <= mduOp_e'(op);
      counter <= (op == MDU_MULT || op == MDU_MULTU) ? MULT_LOAD : DIV_LOAD;
    end else if (busy) begin
      counter <= counter - ONE;
      // The edge ending the last busy cycle commits the result.
      if (counter == ONE) begin
        case (opReg)
          MDU_MULT:  {hi, lo} <= prodS;
          MDU_MULTU: {hi, lo} <= prodU;
          MDU_DIV:   if (bNonZero) begin hi <= remS; lo <= quotS; end
          MDU_DIVU:  if (bNonZero) begin hi <= remU; lo <= quotU; end
          default: ;
        endcase
      end
    end else if (write) begin
      if (op == MDU_MTHI) begin
        hi <= A;
      end else if (op == MDU_MTLO) begin
        lo <= A;
      end
    end
  end

  always_comb begin
    out = '0;
    case (op)
      MDU_MFHI: out = hi;
      MDU_MFLO: out = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected HI/LO/busy-length per
// operation, a monitor compares them each time busy drops.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        we;
  logic        req;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we(we), .req(req),
    .A(A), .B(B), .busy(busy), .out(out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } expT;

  expT expQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Drives one instruction for exactly one clock edge.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn,
                               input logic [31:0] bIn, input logic doStart,
                               input logic doWe, input logic doReq);
    op    = opIn;
    A     = aIn;
    B     = bIn;
    start = doStart;
    we    = doWe;
    req   = doReq;
    @(posedge clk);
    #1;
    start = 1'b0;
    we    = 1'b0;
    req   = 1'b0;
  endtask

  task automatic issueOp(input string name, input logic [2:0] opIn,
                         input logic [31:0] aIn, input logic [31:0] bIn,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input int cycles);
    expT e;
    e.name = name; e.hi = expHi; e.lo = expLo; e.cycles = cycles;
    expQ.push_back(e);
    applyStimulus(opIn, aIn, bIn, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: busy=%0b, pending=%0d, want idle", name, busy, expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: measures each busy run and checks the result when it ends.
  initial begin : monitor
    int   runLen;
    logic prevBusy;
    expT  e;
    runLen   = 0;
    prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        runLen   = 0;
        prevBusy = 1'b0;
      end else begin
        if (busy) begin
          runLen++;
        end else if (prevBusy) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedDone: got completion after %0d cycles, want none", runLen);
          end else begin
            e = expQ.pop_front();
            checkOutput({e.name, ".hi"}, hi, e.hi);
            checkOutput({e.name, ".lo"}, lo, e.lo);
            checkOutput({e.name, ".busyCycles"}, 32'(runLen), 32'(e.cycles));
          end
          runLen = 0;
        end
        prevBusy = busy;
      end
    end
  end

  initial begin : stimulus
    expT e;
    reset = 1'b1; start = 1'b0; we = 1'b0; req = 1'b0;
    op = MDU_MFHI; A = '0; B = '0;
    #3;
    checkOutput("reset.hi", hi, 32'h0);
    checkOutput("reset.lo", lo, 32'h0);
    checkOutput("reset.busy", {31'b0, busy}, 32'h0);
    checkOutput("reset.out", out, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);

    issueOp("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    waitIdle("mult");
    issueOp("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    waitIdle("multu");
    issueOp("divNeg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    waitIdle("divNeg");
    issueOp("divuZero", MDU_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    waitIdle("divuZero");
    issueOp("divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    waitIdle("divu");
    issueOp("divOvf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    waitIdle("divOvf");
    issueOp("divNegDivisor", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
    waitIdle("divNegDivisor");
    issueOp("multBig", MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5);
    waitIdle("multBig");

    applyStimulus(MDU_MTHI, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0);
    op = MDU_MFHI;
    #1;
    checkOutput("mthi.out", out, 32'h1234_5678);
    checkOutput("mthi.lo", lo, 32'h0000_0001);
    applyStimulus(MDU_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 1'b0);
    op = MDU_MFLO;
    #1;
    checkOutput("mtlo.out", out, 32'hCAFE_F00D);
    checkOutput("mtlo.hi", hi, 32'h1234_5678);

    applyStimulus(MDU_MULT, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1);
    checkOutput("reqStart.busy", {31'b0, busy}, 32'h0);
    applyStimulus(MDU_MTHI, 32'h0000_DEAD, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reqBlock.busy", {31'b0, busy}, 32'h0);
    checkOutput("reqBlock.hi", hi, 32'h1234_5678);
    checkOutput("reqBlock.lo", lo, 32'hCAFE_F00D);

    applyStimulus(MDU_MULT, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("abort.busyBefore", {31'b0, busy}, 32'h1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort.busy", {31'b0, busy}, 32'h0);
    checkOutput("abort.hi", hi, 32'h0);
    checkOutput("abort.lo", lo, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abortAfter.busy", {31'b0, busy}, 32'h0);
    checkOutput("abortAfter.hi", hi, 32'h0);
    checkOutput("abortAfter.lo", lo, 32'h0);

    issueOp("b2bFirst", MDU_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5);
    @(posedge clk); #1;
    applyStimulus(MDU_MULT, 32'd100, 32'd100, 1'b1, 1'b0, 1'b0);
    begin
      int n = 0;
      while (busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("b2b.idleReached", {31'b0, busy}, 32'h0);
    end
    e.name = "b2bSecond"; e.hi = 32'h0; e.lo = 32'd42; e.cycles = 5;
    expQ.push_back(e);
    applyStimulus(MDU_MULT, 32'd6, 32'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("b2bSecond.busy", {31'b0, busy}, 32'h1);
    waitIdle("b2bSecond");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
